// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the scoreboarded register file
package regfile_pkg;

    typedef enum logic {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_t;

    localparam int RF_XLEN_DEFAULT = 32;
    localparam int RF_NREG_DEFAULT = 32;

    // An address is usable when it is inside the array and is not the hardwired zero entry.
    function automatic logic rf_addr_ok(input int unsigned addr, input int unsigned nreg,
                                        input int zero_reg);
        return (addr < nreg) && !((zero_reg != 0) && (addr == 0));
    endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// rtl/regfile_sb_scoreboard.sv - pending-writeback busy vector and issue stall
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG     = RF_NREG_DEFAULT,
    parameter int AW       = $clog2(NREG),
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    output logic [NREG-1:0] busy,
    output logic            iss_stall
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            wr_ok;
    logic            iss_ok;
    logic            iss_hit_wr;

    assign wr_ok      = run && wr_en && rf_addr_ok(32'(wr_addr), NREG, ZERO_REG);
    assign iss_ok     = run && iss_en && rf_addr_ok(32'(iss_addr), NREG, ZERO_REG);
    assign iss_hit_wr = wr_en && (wr_addr == iss_addr);

    // A writeback retiring the old producer lets the new one issue; the set is applied last so it wins.
    always_comb begin
        busy_d    = busy_q;
        iss_stall = 1'b1;
        if (run) begin
            iss_stall = iss_ok && busy_q[iss_addr] && !iss_hit_wr;
            if (wr_ok) begin
                busy_d[wr_addr] = 1'b0;
            end
            if (iss_ok && !iss_stall) begin
                busy_d[iss_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-port register file with clear sequencer and destination scoreboard
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = RF_XLEN_DEFAULT,
    parameter int NREG     = RF_NREG_DEFAULT,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    output logic                init_done,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                iss_stall
);

    localparam logic [AW-1:0] LAST_PTR = AW'(NREG - 1);

    rf_state_t       state_q, state_d;
    logic [AW-1:0]   init_ptr_q, init_ptr_d;
    logic            init_done_q, init_done_d;
    logic            run;
    logic            wr_ok;
    logic [NREG-1:0] busy;

    logic [XLEN-1:0] rf_q [NREG];
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;
    logic [AW-1:0]   ra;

    assign run   = (state_q == RF_RUN);
    assign wr_ok = run && wr_en && rf_addr_ok(32'(wr_addr), NREG, ZERO_REG);

    always_comb begin
        state_d     = state_q;
        init_ptr_d  = init_ptr_q;
        init_done_d = init_done_q;
        if (state_q == RF_INIT) begin
            init_ptr_d = init_ptr_q + AW'(1);
            if (init_ptr_q == LAST_PTR) begin
                state_d     = RF_RUN;
                init_done_d = 1'b1;
                init_ptr_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= RF_INIT;
            init_ptr_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            init_done_q <= init_done_d;
        end
    end

    assign init_done = init_done_q;

    // The clear walk shares the single write port, keeping the array free of reset so it maps to RAM.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (state_q == RF_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_ptr_q;
            mem_wdata = '0;
        end else if (wr_ok) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            rf_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        ra      = '0;
        for (int i = 0; i < NRD; i++) begin
            ra = rd_addr[i*AW +: AW];
            if (run && rf_addr_ok(32'(ra), NREG, ZERO_REG)) begin
                if ((BYPASS != 0) && wr_ok && (wr_addr == ra)) begin
                    rd_data[i*XLEN +: XLEN] = wr_data;
                    rd_busy[i]              = 1'b0;
                end else begin
                    rd_data[i*XLEN +: XLEN] = rf_q[ra];
                    rd_busy[i]              = busy[ra];
                end
            end
        end
    end

    rf_scoreboard #(
        .NREG     (NREG),
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .iss_en    (iss_en),
        .iss_addr  (iss_addr),
        .busy      (busy),
        .iss_stall (iss_stall)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Instances a (BYPASS=1) and b (BYPASS=0) share one stimulus set.
    logic        reset_ab;
    logic [9:0]  rd_addr_ab;
    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        iss_stall_a, iss_stall_b;
    logic        init_done_a, init_done_b;

    logic         reset_c;
    logic [14:0]  rd_addr_c;
    logic [191:0] rd_data_c;
    logic [2:0]   rd_busy_c;
    logic         wr_en_c;
    logic [4:0]   wr_addr_c;
    logic [63:0]  wr_data_c;
    logic         iss_en_c;
    logic [4:0]   iss_addr_c;
    logic         iss_stall_c;
    logic         init_done_c;

    regfile_sb #(.BYPASS(1)) dut_a (
        .clk(clk), .reset(reset_ab), .init_done(init_done_a),
        .rd_addr(rd_addr_ab), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_stall(iss_stall_a)
    );

    regfile_sb #(.BYPASS(0)) dut_b (
        .clk(clk), .reset(reset_ab), .init_done(init_done_b),
        .rd_addr(rd_addr_ab), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_stall(iss_stall_b)
    );

    regfile_sb #(.XLEN(64), .NREG(24), .NRD(3)) dut_c (
        .clk(clk), .reset(reset_c), .init_done(init_done_c),
        .rd_addr(rd_addr_c), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
        .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
        .iss_en(iss_en_c), .iss_addr(iss_addr_c), .iss_stall(iss_stall_c)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [4:0]  c_addr [3];
    logic [63:0] c_val  [3];

    initial begin
        int rise_a;
        int rise_c;
        logic [63:0] acc;
        logic [3:0]  bacc;

        c_addr = '{5'd1, 5'd2, 5'd23};
        c_val  = '{64'h1111_2222_3333_4444, 64'hCAFE_F00D_0123_4567, 64'h8000_0000_0000_0001};

        reset_ab = 1'b0; rd_addr_ab = {5'd4, 5'd3};
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b1; iss_addr = 5'd3;
        reset_c = 1'b0; rd_addr_c = '0; wr_en_c = 1'b0; wr_addr_c = '0; wr_data_c = '0;
        iss_en_c = 1'b0; iss_addr_c = '0;
        repeat (3) tick;

        check("rst_init_done", 64'(init_done_a), 64'd0);
        check("rst_rd_data", rd_data_a, 64'd0);
        check("rst_rd_busy", 64'(rd_busy_a), 64'd0);
        check("rst_iss_stall", 64'(iss_stall_a), 64'd1);
        check("rst_c_stall", 64'(iss_stall_c), 64'd1);

        reset_ab = 1'b1;
        reset_c  = 1'b1;
        rise_a = 0;
        rise_c = 0;
        for (int k = 1; k <= 40; k++) begin
            tick;
            if (k == 5) begin
                check("init_iss_stall", 64'(iss_stall_a), 64'd1);
                check("init_rd_data", rd_data_a, 64'd0);
            end
            if (init_done_a && rise_a == 0) begin
                rise_a = k;
                iss_en = 1'b0;
            end
            if (init_done_c && rise_c == 0) rise_c = k;
        end
        check("init_rise_a", 64'(rise_a), 64'd32);
        check("init_rise_c", 64'(rise_c), 64'd24);
        check("init_done_b", 64'(init_done_b), 64'd1);

        rd_addr_ab = {5'd3, 5'd3};
        #1;
        check("init_no_busy", 64'(rd_busy_a), 64'd0);

        acc = '0;
        bacc = '0;
        for (int r = 0; r < 32; r++) begin
            rd_addr_ab = {5'(31 - r), 5'(r)};
            #1;
            acc  = acc | rd_data_a | rd_data_b;
            bacc = bacc | {rd_busy_a, rd_busy_b};
        end
        check("init_all_zero", acc, 64'd0);
        check("init_all_idle", 64'(bacc), 64'd0);

        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        rd_addr_ab = {5'd5, 5'd5};
        tick;
        wr_en = 1'b0;
        #1;
        check("x5_p0", 64'(rd_data_a[31:0]), 64'hDEAD_BEEF);
        check("x5_p1", 64'(rd_data_a[63:32]), 64'hDEAD_BEEF);
        check("x5_b_p0", 64'(rd_data_b[31:0]), 64'hDEAD_BEEF);

        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234;
        rd_addr_ab = {5'd0, 5'd0};
        #1;
        check("x0_bypass", rd_data_a, 64'd0);
        tick;
        wr_en = 1'b0;
        #1;
        check("x0_read_a", rd_data_a, 64'd0);
        check("x0_read_b", rd_data_b, 64'd0);

        rd_addr_ab = {5'd5, 5'd7};
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5;
        #1;
        check("byp_data", 64'(rd_data_a[31:0]), 64'hA5A5_A5A5);
        check("byp_busy", 64'(rd_busy_a[0]), 64'd0);
        check("nobyp_old", 64'(rd_data_b[31:0]), 64'd0);
        check("port1_indep", 64'(rd_data_a[63:32]), 64'hDEAD_BEEF);
        tick;
        wr_en = 1'b0;
        #1;
        check("nobyp_new", 64'(rd_data_b[31:0]), 64'hA5A5_A5A5);

        rd_addr_ab = {5'd0, 5'd3};
        iss_en = 1'b1; iss_addr = 5'd3;
        #1;
        check("iss_free", 64'(iss_stall_a), 64'd0);
        check("iss_same_cycle_busy", 64'(rd_busy_a[0]), 64'd0);
        tick;
        check("busy_set_a", 64'(rd_busy_a[0]), 64'd1);
        check("busy_set_b", 64'(rd_busy_b[0]), 64'd1);
        check("waw_stall", 64'(iss_stall_a), 64'd1);
        tick;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        #1;
        check("waw_wb_nostall", 64'(iss_stall_a), 64'd0);
        check("wb_byp_busy", 64'(rd_busy_a[0]), 64'd0);
        check("wb_nobyp_busy", 64'(rd_busy_b[0]), 64'd1);
        tick;
        iss_en = 1'b0;
        wr_en  = 1'b0;
        #1;
        check("iss_wins_busy", 64'(rd_busy_a[0]), 64'd1);
        check("iss_wins_data", 64'(rd_data_a[31:0]), 64'h33);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h44;
        tick;
        wr_en = 1'b0;
        #1;
        check("wb_clear_a", 64'(rd_busy_a[0]), 64'd0);
        check("wb_clear_b", 64'(rd_busy_b[0]), 64'd0);

        iss_en = 1'b1; iss_addr = 5'd0;
        tick;
        check("x0_iss_nostall", 64'(iss_stall_a), 64'd0);
        iss_en = 1'b0;

        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h2020;
        iss_en = 1'b1; iss_addr = 5'd12;
        tick;
        wr_en = 1'b0;
        iss_en = 1'b0;
        rd_addr_ab = {5'd12, 5'd20};
        #1;
        check("pre_x20", 64'(rd_data_a[31:0]), 64'h2020);
        check("pre_busy12", 64'(rd_busy_a[1]), 64'd1);

        reset_ab = 1'b0;
        tick;
        reset_ab = 1'b1;
        repeat (10) tick;
        reset_ab = 1'b0;
        tick;
        check("mid_rst_done", 64'(init_done_a), 64'd0);
        reset_ab = 1'b1;
        rise_a = 0;
        for (int k = 1; k <= 40; k++) begin
            tick;
            if (init_done_a && rise_a == 0) rise_a = k;
        end
        check("mid_rise", 64'(rise_a), 64'd32);
        check("x20_cleared", 64'(rd_data_a[31:0]), 64'd0);
        check("busy_dropped", 64'(rd_busy_a), 64'd0);

        wr_en_c = 1'b1; wr_addr_c = 5'd30; wr_data_c = 64'hFFFF_FFFF_FFFF_FFFF;
        rd_addr_c = {5'd0, 5'd0, 5'd30};
        #1;
        check("c_oor_byp", rd_data_c[63:0], 64'd0);
        tick;
        wr_en_c = 1'b0;
        #1;
        check("c_oor_read", rd_data_c[63:0], 64'd0);
        iss_en_c = 1'b1; iss_addr_c = 5'd30;
        tick;
        check("c_oor_iss", 64'(iss_stall_c), 64'd0);
        check("c_oor_busy", 64'(rd_busy_c), 64'd0);
        iss_en_c = 1'b0;

        for (int j = 0; j < 3; j++) begin
            wr_en_c = 1'b1; wr_addr_c = c_addr[j]; wr_data_c = c_val[j];
            tick;
        end
        wr_en_c = 1'b0;
        rd_addr_c = {5'd23, 5'd2, 5'd1};
        #1;
        check("c_port0_x1", rd_data_c[0 +: 64], 64'h1111_2222_3333_4444);
        check("c_port1_x2", rd_data_c[64 +: 64], 64'hCAFE_F00D_0123_4567);
        check("c_port2_x23", rd_data_c[128 +: 64], 64'h8000_0000_0000_0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a built-in destination scoreboard and a sequential clear sequencer. It is the next-generation replacement for the single-cycle CPU's 32x32 two-read register file, intended for the pipelined/multi-cycle core. It provides a configurable number of combinational read ports and one write port. It hardwires x0 to zero and can optionally bypass write data to the read ports. It tracks pending writebacks so the issue stage can detect RAW and WAW hazards. Storage is cleared after reset by walking one entry per cycle rather than by flop reset, so the array can map to distributed RAM.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (2..64)
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes/issues
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
- AW, derived = clog2(NREG), address width
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- init_done  out  1  high once the clear sequence has finished
- rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
- rd_busy  out  NRD  scoreboard bit of each addressed register
- wr_en  in  1  writeback strobe
- wr_addr  in  AW  writeback destination
- wr_data  in  XLEN  writeback data
- iss_en  in  1  issue strobe, marks iss_addr pending
- iss_addr  in  AW  destination of the issuing instruction
- iss_stall  out  1  issue refused this cycle

## Operation
- FSM states are RF_INIT and RF_RUN.
  - reset low → RF_INIT, init_ptr=0, all busy bits=0, init_done=0.
  - In RF_INIT, entry init_ptr is written with 0 and init_ptr increments each cycle. The cycle that writes NREG-1 transitions to RF_RUN.
  - RF_RUN is held until reset.
- In RF_INIT:
  - wr_en and iss_en are ignored.
  - rd_data=0, rd_busy=0, iss_stall=1.
- Write (RF_RUN):
  - wr_en writes wr_data to wr_addr and clears busy[wr_addr].
  - Ignored when ZERO_REG and wr_addr=0.
  - Ignored when wr_addr ≥ NREG.
- Issue (RF_RUN):
  - iss_stall = iss_en & busy[iss_addr] & !(wr_en & wr_addr==iss_addr). This is a WAW on an outstanding producer.
  - If iss_en & !iss_stall, set busy[iss_addr].
  - iss_addr=0 with ZERO_REG, and iss_addr ≥ NREG, never stall and set nothing.
- Simultaneous issue and write to the same register: data is written, and busy ends up SET (new producer wins).
- Read ports are combinational and independent:
  - Address 0 with ZERO_REG returns 0 with busy 0.
  - Address ≥ NREG returns 0 with busy 0.
  - With BYPASS, if wr_en & wr_addr==rd_addr[i] (writable address), then rd_data[i]=wr_data and rd_busy[i]=0.
  - Otherwise the port returns the stored entry and busy bit.
- Reset asserted mid-operation (including mid-RF_INIT) restarts the clear from entry 0. Pending busy bits are dropped.

## Timing
- Reset values: init_done=0, rd_data=0, rd_busy=0, iss_stall=1.
- init_done rises exactly NREG cycles after the first clock edge with reset high.
- Read latency is 0 cycles (combinational).
- Write becomes visible:
  - the same cycle with BYPASS=1;
  - the next cycle otherwise.
- A busy bit becomes visible on rd_busy the cycle after issue. The clear is visible the same cycle (BYPASS=1) or the next cycle (BYPASS=0).
- No handshake backpressure on writes: every RF_RUN wr_en is accepted.

## Structure
- Shared package regfile_pkg holds the rf_state_t enum (RF_INIT, RF_RUN) and default XLEN/NREG constants shared with the decode stage.
- Sub-module rf_scoreboard holds the NREG busy vector, the issue/clear priority logic and the iss_stall generation. The top level holds the storage array, the init FSM and the read muxing.
- Storage has no reset on the array itself; only the FSM, init_ptr and the scoreboard are reset.

## Test plan
- **Init:** hold reset low 3 cycles, release. Required: init_done=0 for 32 cycles, 1 on cycle 32. All 32 entries read 0. iss_en during init gives iss_stall=1 and no busy bit set.
- **Write/read with x0:**
  - write 0xDEADBEEF to x5, then read x5 on ports 0 and 1 → 0xDEADBEEF on both;
  - write 0x1234 to x0, then read x0 → 0.
- **Bypass:** BYPASS=1, wr_en x7=0xA5A5A5A5 with rd_addr0=7 in the same cycle → rd_data0=0xA5A5A5A5, rd_busy0=0. Repeat with BYPASS=0 → old value this cycle, new value next cycle.
- **Scoreboard:**
  - issue x3 → rd_busy=1 for x3 the next cycle;
  - issue x3 again → iss_stall=1;
  - issue x3 again in the same cycle as writeback x3 → no stall, x3 data written, busy stays 1.
- **Reset mid-init:** assert reset at init_ptr=10, release → init_done rises exactly NREG cycles after release. An entry written before the reset reads 0.
- **Parametrisation:** NREG=24, NRD=3, XLEN=64.
  - write to address 30 → ignored, reads 0;
  - all three ports read distinct registers correctly in the same cycle.
